// File: rtl/seg_led_display_if.sv
// rtl/seg_led_display_if.sv - display/LED bus between board logic and seg_led_display
// Optional SEG_BLINK_EN adds the per-digit blink mask.
interface seg_led_display_if #(
  parameter int DIGITS = 4,
  parameter int LED_W  = 16
);
  logic [4*DIGITS-1:0] digit_data;
  logic [DIGITS-1:0]   digit_en;
  logic [DIGITS-1:0]   dp_in;
  logic [1:0]          led_mode;
`ifdef SEG_BLINK_EN
  logic [DIGITS-1:0]   blink;
`endif
  logic [DIGITS-1:0]   sel;
  logic [6:0]          light;
  logic                dp;
  logic [LED_W-1:0]    leds;

`ifdef SEG_BLINK_EN
  modport master (output digit_data, digit_en, dp_in, led_mode, blink,
                  input  sel, light, dp, leds);
  modport slave  (input  digit_data, digit_en, dp_in, led_mode, blink,
                  output sel, light, dp, leds);
`else
  modport master (output digit_data, digit_en, dp_in, led_mode,
                  input  sel, light, dp, leds);
  modport slave  (input  digit_data, digit_en, dp_in, led_mode,
                  output sel, light, dp, leds);
`endif
endinterface

// File: rtl/seg_led_display.sv
// rtl/seg_led_display.sv - multiplexed seven-segment scanner and animated LED bar
// Optional SEG_BLINK_EN: blink mask toggles masked digits every 256 scan steps.
module seg_led_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int LED_W    = 16,
  parameter int LED_DIV  = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  seg_led_display_if.slave bus
);
  localparam int SCAN_CW = $clog2(SCAN_DIV + 1);
  localparam int LED_CW  = $clog2(LED_DIV + 1);
  localparam int IDX_W   = $clog2(DIGITS);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } led_mode_t;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'b0000001;
      4'h1: hex_decode = 7'b1001111;
      4'h2: hex_decode = 7'b0010010;
      4'h3: hex_decode = 7'b0000110;
      4'h4: hex_decode = 7'b1001100;
      4'h5: hex_decode = 7'b0100100;
      4'h6: hex_decode = 7'b0100000;
      4'h7: hex_decode = 7'b0001111;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0000100;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b1100000;
      4'hC: hex_decode = 7'b0110001;
      4'hD: hex_decode = 7'b1000010;
      4'hE: hex_decode = 7'b0110000;
      default: hex_decode = 7'b0111000;
    endcase
  endfunction

  logic [SCAN_CW-1:0] scan_cnt;
  logic [LED_CW-1:0]  led_cnt;
  logic               scan_tick;
  logic               led_tick;
  logic [IDX_W-1:0]   idx;
  logic [DIGITS-1:0]  sel_q;
  logic [6:0]         light_q;
  logic               dp_q;
  logic [LED_W-1:0]   leds_q;
  logic               dir_left;
  led_mode_t          last_mode;
  led_mode_t          mode_in;
  logic [DIGITS-1:0]  vis;
  logic [3:0]         nib;
  logic               shown;

  assign scan_tick = (scan_cnt == SCAN_CW'(SCAN_DIV - 1));
  assign led_tick  = (led_cnt == LED_CW'(LED_DIV - 1));
  assign mode_in   = led_mode_t'(bus.led_mode);

`ifdef SEG_BLINK_EN
  logic [7:0] blink_cnt;
  logic       blink_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (scan_tick) begin
      blink_cnt <= blink_cnt + 8'd1;
      if (blink_cnt == 8'hFF) blink_on <= ~blink_on;
    end
  end

  // Off phase hides blinking digits exactly as if they were disabled.
  assign vis = bus.digit_en & ~(bus.blink & {DIGITS{~blink_on}});
`else
  assign vis = bus.digit_en;
`endif

  assign nib   = bus.digit_data[{idx, 2'b00} +: 4];
  assign shown = vis[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      sel_q    <= '1;
      light_q  <= 7'b1111111;
      dp_q     <= 1'b1;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      sel_q    <= ~(DIGITS'(1) << idx);
      light_q  <= shown ? hex_decode(nib) : 7'b1111111;
      dp_q     <= ~(bus.dp_in[idx] & shown);
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A mode change only loads the start frame; animation resumes on the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_cnt   <= '0;
      leds_q    <= '0;
      dir_left  <= 1'b1;
      last_mode <= MODE_OFF;
    end else if (led_tick) begin
      led_cnt <= '0;
      if (mode_in != last_mode) begin
        leds_q    <= (mode_in == MODE_OFF) ? '0 : LED_W'(1);
        dir_left  <= 1'b1;
        last_mode <= mode_in;
      end else begin
        case (last_mode)
          MODE_OFF: leds_q <= '0;
          MODE_ROTATE: begin
            if (leds_q == '0) leds_q <= LED_W'(1);
            else              leds_q <= {leds_q[LED_W-2:0], leds_q[LED_W-1]};
          end
          MODE_BOUNCE: begin
            if (leds_q == '0) begin
              leds_q <= LED_W'(1);
            end else if (dir_left) begin
              if (leds_q[LED_W-1]) begin
                leds_q   <= leds_q >> 1;
                dir_left <= 1'b0;
              end else begin
                leds_q <= leds_q << 1;
              end
            end else begin
              if (leds_q[0]) begin
                leds_q   <= leds_q << 1;
                dir_left <= 1'b1;
              end else begin
                leds_q <= leds_q >> 1;
              end
            end
          end
          default: leds_q <= {leds_q[LED_W-2:0], ~leds_q[LED_W-1]};
        endcase
      end
    end else begin
      led_cnt <= led_cnt + 1'b1;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.light = light_q;
  assign bus.dp    = dp_q;
  assign bus.leds  = leds_q;
endmodule

// File: tb/tb_seg_led_display.sv
// tb/tb_seg_led_display.sv - scoreboard bench for seg_led_display
module tb_seg_led_display;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   led_next;

  typedef struct {
    int       edge_no;
    logic [3:0] sel;
    logic [6:0] light;
    logic       dp;
  } scan_item_t;

  typedef struct {
    int         edge_no;
    logic [7:0] leds;
  } led_item_t;

  scan_item_t scan_q[$];
  led_item_t  led_q[$];
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg_led_display_if #(.DIGITS(4), .LED_W(8)) bus ();

  seg_led_display #(.DIGITS(4), .SCAN_DIV(4), .LED_W(8), .LED_DIV(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (scan_q.size() > 0 && scan_q[0].edge_no == edge_n) begin
        scan_item_t s;
        s = scan_q.pop_front();
        check("sel", 32'(bus.sel), 32'(s.sel));
        check("light", 32'(bus.light), 32'(s.light));
        check("dp", 32'(bus.dp), 32'(s.dp));
      end
      if (led_q.size() > 0 && led_q[0].edge_no == edge_n) begin
        led_item_t l;
        l = led_q.pop_front();
        check("leds", 32'(bus.leds), 32'(l.leds));
      end
    end
  end

  task automatic push_scan(input int n);
    int t;
    int idx;
    logic sh;
    logic [15:0] data;
    scan_item_t s;
    t = (edge_n / 4 + 1) * 4;
    data = bus.digit_data;
    for (int k = 0; k < n; k++) begin
      idx       = (t / 4 - 1 + k) % 4;
      sh        = bus.digit_en[idx];
      s.edge_no = t + 4 * k;
      s.sel     = ~(4'b0001 << idx);
      s.light   = sh ? seg_tab[data[idx*4 +: 4]] : 7'h7F;
      s.dp      = ~(bus.dp_in[idx] & sh);
      scan_q.push_back(s);
    end
  endtask

  task automatic led_start();
    led_next = (edge_n / 3 + 1) * 3;
  endtask

  task automatic push_led(input logic [7:0] v);
    led_item_t l;
    l.edge_no = led_next;
    l.leds    = v;
    led_q.push_back(l);
    led_next += 3;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000; i++) begin
      if (scan_q.size() == 0 && led_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", 32'(scan_q.size() + led_q.size()), 32'd0);
    scan_q.delete();
    led_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_sel", 32'(bus.sel), 32'hF);
    check("rst_light", 32'(bus.light), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'h1);
    check("rst_leds", 32'(bus.leds), 32'h0);
  endtask

`ifdef SEG_BLINK_EN
  initial bus.blink = '0;
`endif

  initial begin
    bus.digit_data = 16'h0;
    bus.digit_en   = 4'h0;
    bus.dp_in      = 4'h0;
    bus.led_mode   = 2'b00;
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Full scan over F,3,C,1 with every digit enabled
    bus.digit_data = 16'h1C3F;
    bus.digit_en   = 4'hF;
    bus.dp_in      = 4'h0;
    push_scan(5);
    wait_drain();

    // Blanking and decimal points
    bus.digit_en = 4'b1011;
    bus.dp_in    = 4'b0110;
    push_scan(4);
    wait_drain();

    // Rotate: load 0x01, walk to 0x80, wrap with no zero frame
    bus.led_mode = 2'b01;
    led_start();
    for (int i = 0; i < 8; i++) push_led(8'(1 << i));
    push_led(8'h01);
    push_led(8'h02);
    wait_drain();

    // Bounce: each endpoint shown for one tick
    bus.led_mode = 2'b10;
    led_start();
    for (int i = 0; i < 8; i++) push_led(8'(1 << i));
    for (int i = 6; i >= 0; i--) push_led(8'(1 << i));
    push_led(8'h02);
    wait_drain();

    // Johnson fill then drain
    bus.led_mode = 2'b11;
    led_start();
    for (int i = 1; i <= 8; i++) push_led(8'((1 << i) - 1));
    for (int i = 1; i <= 8; i++) push_led(8'(32'hFF << i));
    push_led(8'h01);
    push_led(8'h03);
    push_led(8'h07);
    wait_drain();

    // Off mid-sequence clears at the next tick
    bus.led_mode = 2'b00;
    led_start();
    push_led(8'h00);
    push_led(8'h00);
    wait_drain();

    // Asynchronous reset with scan at idx 2 and leds = 0x20
    rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    bus.digit_data = 16'h1C3F;
    bus.digit_en   = 4'hF;
    bus.dp_in      = 4'h0;
    bus.led_mode   = 2'b01;
    push_scan(11);
    led_start();
    for (int i = 0; i < 8; i++) push_led(8'(1 << i));
    for (int i = 0; i < 6; i++) push_led(8'(1 << i));
    for (int i = 0; i < 200 && edge_n != 44; i++) @(negedge clk);
    #1;
    check("reach_edge44", 32'(edge_n), 32'd44);
    check("pre_sel", 32'(bus.sel), 32'hB);
    check("pre_leds", 32'(bus.leds), 32'h20);
    check("pre_queues", 32'(scan_q.size() + led_q.size()), 32'd0);
    rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    push_scan(1);
    led_start();
    push_led(8'h01);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_led_display.md
Name: seg_led_display

Overview:
- Parametrised board status display for the RISC-V CPU top level.
- Time-multiplexes DIGITS seven-segment digits from packed hex nibbles, with per-digit blanking and decimal points.
- Drives a LED_W-bit LED bar through one of four selectable animation modes.
- All timing derives from the single board clock via internal tick dividers.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 100000, clk cycles per digit-scan step.
- LED_W, 16, LED bar width (>=2).
- LED_DIV, 5000000, clk cycles per LED animation step.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-high reset.
- digit_data  in  4*DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
- digit_en  in  DIGITS  1 = digit i shown, 0 = blanked.
- dp_in  in  DIGITS  1 = decimal point of digit i lit.
- led_mode  in  2  00 off, 01 rotate, 10 bounce, 11 Johnson fill.
- sel  out  DIGITS  digit select, active-low, one-cold.
- light  out  7  segments, active-low; light[6]=a … light[0]=g.
- dp  out  1  decimal point, active-low.
- leds  out  LED_W  LED bar, active-high.

Behaviour:
- Reset (async, active-high, all state):
  - sel = all ones, light = 7'b1111111, dp = 1, leds = 0.
  - Scan index = 0; both divider counters = 0; bounce direction = left; last-mode register = 00.
- Dividers:
  - Each divider counts 0..DIV-1.
  - On the edge where count == DIV-1: count returns to 0 and the associated update executes; otherwise count increments.
  - The first update occurs on the DIV-th rising edge after reset release.
- Scan update (inputs sampled at that edge):
  - sel = ~(1 << idx).
  - light = decode(nibble idx) if digit_en[idx], else 7'b1111111.
  - dp = ~(dp_in[idx] & digit_en[idx]).
  - idx increments, wrapping DIGITS-1 -> 0.
  - Outputs hold between updates.
- Hex decode (abcdefg, active-low):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- LED update, evaluated on each LED tick:
  - If led_mode != last-mode: load the start pattern (00 -> 0, others -> 1), set direction = left, store the new mode. No animation step that tick.
  - Otherwise, by mode:
    - 00: leds = 0.
    - 01: rotate left; MSB wraps to bit0; no all-zero frame.
    - 10: one-hot step in the current direction. At bit LED_W-1 the direction flips to right; at bit0 it flips to left. The flip and the move happen on the same tick, so the endpoint is shown for exactly one tick.
    - 11: leds = {leds[LED_W-2:0], ~leds[LED_W-1]}; period 2*LED_W.
  - If leds == 0 in mode 01/10 (corruption guard): load 1.
- Simultaneous scan and LED ticks are independent; both update on the same edge.
- Reset mid-scan or mid-animation returns everything to the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro SEG_BLINK_EN.
- When defined:
  - Extra input port blink, width DIGITS.
  - Internal 8-bit counter of scan updates; blink phase toggles each time it wraps (every 256 scan updates); phase resets to "on".
  - During the off phase, digits with blink[i]=1 are treated as digit_en[i]=0, including dp.
- When undefined: no blink port, no counter, behaviour exactly as above.

Test Plan (DIGITS=4, SCAN_DIV=4, LED_W=8, LED_DIV=3):
- Reset, then digit_data=16'h1C3F, digit_en=4'hF, dp_in=0 -> after edge 4: sel=1110, light=0111000. Edge 8: sel=1101, light=0000110. Edge 12: sel=1011, light=0110001. Edge 16: sel=0111, light=1001111. Edge 20: sel=1110 again.
- digit_en=4'b1011, dp_in=4'b0110 -> idx2 shows light=1111111, dp=1. idx1 shows dp=0. idx0 shows dp=1.
- led_mode=01 from reset -> first LED tick (edge 3) loads 0x01. Subsequent ticks: 0x02 … 0x80, then 0x01 with no zero frame.
- led_mode=10 -> 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02; each endpoint held exactly one tick.
- led_mode=11 -> 0x01, 0x03, 0x07 … 0xFF, 0xFE, 0xFC … 0x00, 0x01. Switching to 00 mid-sequence -> leds=0 at the next LED tick.
- Assert rst while scanning at idx 2 with leds=0x20 -> sel=1111, light=1111111, dp=1, leds=0 before the next clk edge. After release, the first scan update is at edge 4 with sel=1110.
